// File: rtl/uart_pkg.sv
// Shared UART definitions used by the baud generator and its channels.
//   UART_DIV_MIN     : smallest legal half-bit divisor
//   UART_FRAC_W      : width of the fractional divisor / accumulator
//   UART_DEFAULT_DIV : half-bit divisor after reset (100 MHz / 115200 / 2)
//   chan_state_t     : per-channel bit-clock state
package uart_pkg;

    localparam int unsigned UART_DIV_MIN     = 2;
    localparam int unsigned UART_FRAC_W      = 4;
    localparam int unsigned UART_DEFAULT_DIV = 434;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } chan_state_t;

endpackage

// File: rtl/uart_baud_chan.sv
// One baud clock channel: idles high, starts a phase-aligned bit clock
// (low half first) when enabled, returns high as soon as enable drops.
// Optional macro UART_BAUD_FRAC_EN adds a fractional accumulator that
// stretches individual half-periods by one cycle on carry-out.
// Ports:
//   clk, rst    : system clock, synchronous active-high reset
//   en          : client enable request (uart_enable)
//   div_sh      : shadow half-bit divisor, captured on IDLE->RUN
//   frac_sh     : shadow fractional divisor (macro builds only)
//   clk_out     : registered bit clock to the client, idle 1
//   run_nxt_c   : combinational next-state-is-RUN, used for busy
module uart_baud_chan
    import uart_pkg::*;
#(
    parameter int unsigned DIV_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [DIV_W-1:0]       div_sh,
`ifdef UART_BAUD_FRAC_EN
    input  logic [UART_FRAC_W-1:0] frac_sh,
`endif
    output logic                   clk_out,
    output logic                   run_nxt_c
);

    chan_state_t      state_q, state_n;
    logic [DIV_W-1:0] cnt_q, cnt_n;
    logic [DIV_W-1:0] div_q, div_n;
    logic             clk_n;
    logic [DIV_W:0]   hlen_c;
    logic             half_end_c;

`ifdef UART_BAUD_FRAC_EN
    logic [UART_FRAC_W-1:0] acc_q, acc_n;
    logic [UART_FRAC_W-1:0] frac_q, frac_n;
    logic                   carry_q, carry_n;

    // Current half-period is one cycle longer after an accumulator carry
    assign hlen_c = {1'b0, div_q} + (DIV_W+1)'(carry_q);
`else
    assign hlen_c = {1'b0, div_q};
`endif

    // Last cycle of the current half-period (cnt == H-1), computed one bit wider
    assign half_end_c = (({1'b0, cnt_q} + (DIV_W+1)'(1)) == hlen_c);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            clk_out <= 1'b1;
`ifdef UART_BAUD_FRAC_EN
            acc_q   <= '0;
            frac_q  <= '0;
            carry_q <= 1'b0;
`endif
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            div_q   <= div_n;
            clk_out <= clk_n;
`ifdef UART_BAUD_FRAC_EN
            acc_q   <= acc_n;
            frac_q  <= frac_n;
            carry_q <= carry_n;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE:    if (en)  state_n = RUN;
            RUN:     if (!en) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign run_nxt_c = (state_n == RUN);

    // Counter, divisor capture and bit-clock next values
    always_comb begin
        cnt_n = cnt_q;
        div_n = div_q;
        clk_n = clk_out;
`ifdef UART_BAUD_FRAC_EN
        acc_n   = acc_q;
        frac_n  = frac_q;
        carry_n = carry_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_n = '0;
                clk_n = 1'b1;
`ifdef UART_BAUD_FRAC_EN
                acc_n   = '0;
                carry_n = 1'b0;
`endif
                if (en) begin
                    div_n = div_sh;
                    clk_n = 1'b0;
`ifdef UART_BAUD_FRAC_EN
                    frac_n = frac_sh;
`endif
                end
            end
            RUN: begin
                if (!en) begin
                    // Abandon the partial half-period and park high
                    cnt_n = '0;
                    clk_n = 1'b1;
`ifdef UART_BAUD_FRAC_EN
                    acc_n   = '0;
                    carry_n = 1'b0;
`endif
                end else if (half_end_c) begin
                    cnt_n = '0;
                    clk_n = ~clk_out;
`ifdef UART_BAUD_FRAC_EN
                    {carry_n, acc_n} = (UART_FRAC_W+1)'(acc_q) + (UART_FRAC_W+1)'(frac_q);
`endif
                end else begin
                    cnt_n = cnt_q + DIV_W'(1);
                end
            end
            default: begin
                cnt_n = '0;
                clk_n = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/uart_baud_gen.sv
// Dual-channel UART baud clock generator (tx and rx) sharing one
// programmable half-bit divisor held in a shadow register. Each channel
// captures the shadow when it starts, so loads never disturb running clocks.
// Optional macro UART_BAUD_FRAC_EN enables fractional divisors (div_frac).
// Ports:
//   clk, rst              : system clock, synchronous active-high reset
//   tx_en, rx_en          : enable requests from transmitter / receiver
//   div_int, div_frac     : new half-bit divisor (integer / 1/16ths)
//   div_load              : strobe latching div_int/div_frac into the shadow
//   clk_uart_tx/rx        : bit clocks to transmitter / receiver, idle 1
//   div_clamped           : sticky, last load had div_int below the minimum
//   busy                  : at least one channel running
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned DEFAULT_DIV = UART_DEFAULT_DIV
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tx_en,
    input  logic                   rx_en,
    input  logic [DIV_W-1:0]       div_int,
    input  logic [UART_FRAC_W-1:0] div_frac,
    input  logic                   div_load,
    output logic                   clk_uart_tx,
    output logic                   clk_uart_rx,
    output logic                   div_clamped,
    output logic                   busy
);

    logic [DIV_W-1:0] div_sh;
    logic             tx_run_nxt_c;
    logic             rx_run_nxt_c;

`ifdef UART_BAUD_FRAC_EN
    logic [UART_FRAC_W-1:0] frac_sh;

    // Fractional shadow follows every load
    always_ff @(posedge clk) begin
        if (rst)           frac_sh <= '0;
        else if (div_load) frac_sh <= div_frac;
    end
`else
    logic unused_frac;
    assign unused_frac = ^div_frac;
`endif

    // Integer shadow with clamp to the minimum legal divisor
    always_ff @(posedge clk) begin
        if (rst) begin
            div_sh      <= DIV_W'(DEFAULT_DIV);
            div_clamped <= 1'b0;
        end else if (div_load) begin
            if (div_int < DIV_W'(UART_DIV_MIN)) begin
                div_sh      <= DIV_W'(UART_DIV_MIN);
                div_clamped <= 1'b1;
            end else begin
                div_sh      <= div_int;
                div_clamped <= 1'b0;
            end
        end
    end

    // Registered from the channels' next state so busy tracks state == RUN
    always_ff @(posedge clk) begin
        if (rst) busy <= 1'b0;
        else     busy <= tx_run_nxt_c | rx_run_nxt_c;
    end

    uart_baud_chan #(.DIV_W(DIV_W)) u_tx (
        .clk       (clk),
        .rst       (rst),
        .en        (tx_en),
        .div_sh    (div_sh),
`ifdef UART_BAUD_FRAC_EN
        .frac_sh   (frac_sh),
`endif
        .clk_out   (clk_uart_tx),
        .run_nxt_c (tx_run_nxt_c)
    );

    uart_baud_chan #(.DIV_W(DIV_W)) u_rx (
        .clk       (clk),
        .rst       (rst),
        .en        (rx_en),
        .div_sh    (div_sh),
`ifdef UART_BAUD_FRAC_EN
        .frac_sh   (frac_sh),
`endif
        .clk_out   (clk_uart_rx),
        .run_nxt_c (rx_run_nxt_c)
    );

endmodule

// File: tb/tb_uart_baud_gen.sv
// Bench for uart_baud_gen: directed and randomized enable/load sequences,
// every cycle compared against a waveform model built from half-period sums.
module tb_uart_baud_gen;

    localparam int unsigned DIV_W = 16;
`ifdef UART_BAUD_FRAC_EN
    localparam bit FRAC_ON = 1'b1;
`else
    localparam bit FRAC_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             tx_en;
    logic             rx_en;
    logic [DIV_W-1:0] div_int;
    logic [3:0]       div_frac;
    logic             div_load;
    logic             clk_uart_tx;
    logic             clk_uart_rx;
    logic             div_clamped;
    logic             busy;

    always #5 clk = ~clk;

    uart_baud_gen #(.DIV_W(DIV_W), .DEFAULT_DIV(434)) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_en       (tx_en),
        .rx_en       (rx_en),
        .div_int     (div_int),
        .div_frac    (div_frac),
        .div_load    (div_load),
        .clk_uart_tx (clk_uart_tx),
        .clk_uart_rx (clk_uart_rx),
        .div_clamped (div_clamped),
        .busy        (busy)
    );

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int edge_no = 0;

    // Reference model: shadow divisor plus, per channel, start edge and captured divisor
    int m_div     = 434;
    int m_frac    = 0;
    bit m_clamped = 1'b0;
    bit m_run [2];
    int m_t0  [2];
    int m_dh  [2];
    int m_fr  [2];

    // Level after 'elapsed' edges since start: walk half-periods; half k (k>=1)
    // gains one cycle whenever floor(k*fr/16) steps up.
    function automatic bit exp_level(int elapsed, int dh, int fr);
        int k = 0;
        int e = elapsed;
        int h = dh;
        while (e >= h) begin
            e = e - h;
            k = k + 1;
            h = dh + (k * fr) / 16 - ((k - 1) * fr) / 16;
        end
        return k[0];
    endfunction

    function automatic bit exp_out(int c);
        if (!m_run[c]) return 1'b1;
        return exp_level(edge_no - m_t0[c], m_dh[c], m_fr[c]);
    endfunction

    task automatic model_edge();
        bit en [2];
        en[0] = tx_en;
        en[1] = rx_en;
        edge_no++;
        if (rst) begin
            m_div     = 434;
            m_frac    = 0;
            m_clamped = 1'b0;
            for (int c = 0; c < 2; c++) m_run[c] = 1'b0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (!m_run[c] && en[c]) begin
                    m_run[c] = 1'b1;
                    m_t0[c]  = edge_no;
                    m_dh[c]  = m_div;
                    m_fr[c]  = FRAC_ON ? m_frac : 0;
                end else if (m_run[c] && !en[c]) begin
                    m_run[c] = 1'b0;
                end
            end
            if (div_load) begin
                if (int'(div_int) < 2) begin
                    m_div     = 2;
                    m_clamped = 1'b1;
                end else begin
                    m_div     = int'(div_int);
                    m_clamped = 1'b0;
                end
                m_frac = int'(div_frac);
            end
        end
    endtask

    task automatic chk(string tag, logic obs, logic expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s @edge %0d: observed %b expected %b", tag, edge_no, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("clk_uart_tx", clk_uart_tx, exp_out(0));
        chk("clk_uart_rx", clk_uart_rx, exp_out(1));
        chk("busy", busy, m_run[0] | m_run[1]);
        chk("div_clamped", div_clamped, m_clamped);
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic load(int d, int f);
        div_int  = DIV_W'(d);
        div_frac = 4'(f);
        div_load = 1'b1;
        tick();
        div_load = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        tx_en    = 1'b0;
        rx_en    = 1'b0;
        div_int  = '0;
        div_frac = '0;
        div_load = 1'b0;

        // Reset, then default divisor on tx
        ticks(3);
        rst = 1'b0;
        tick();
        tx_en = 1'b1;
        ticks(880);
        tx_en = 1'b0;
        tick();

        // H=4 on tx, rx started three edges later, tx dropped while rx runs
        load(4, 0);
        tx_en = 1'b1;
        tick();
        ticks(2);
        rx_en = 1'b1;
        tick();
        ticks(6);
        tx_en = 1'b0;
        tick();
        ticks(10);
        rx_en = 1'b0;
        tick();

        // Load while running has no effect until restart; immediate re-enable
        tx_en = 1'b1;
        ticks(6);
        load(6, 0);
        ticks(12);
        tx_en = 1'b0;
        tick();
        tx_en = 1'b1;
        ticks(20);

        // Clamp and clear
        load(1, 0);
        tx_en = 1'b0;
        tick();
        tx_en = 1'b1;
        ticks(12);
        load(0, 0);
        ticks(3);
        load(3, 0);
        ticks(4);

        // Start coinciding with a load uses the old shadow
        tx_en = 1'b0;
        tick();
        tx_en    = 1'b1;
        div_int  = DIV_W'(7);
        div_load = 1'b1;
        tick();
        div_load = 1'b0;
        ticks(14);

        // Fractional divisor (integer-only build ignores div_frac), simultaneous start
        tx_en = 1'b0;
        tick();
        load(4, 8);
        tx_en = 1'b1;
        rx_en = 1'b1;
        ticks(150);

        // Reset mid low half with enables held, restart on default divisor
        tx_en = 1'b0;
        rx_en = 1'b0;
        tick();
        tx_en = 1'b1;
        rx_en = 1'b1;
        ticks(2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ticks(440);

        // Randomized loads and enable patterns
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 2) == 0)
                load(int'($urandom_range(0, 9)), int'($urandom_range(0, 15)));
            tx_en = 1'($urandom_range(0, 1));
            rx_en = 1'($urandom_range(0, 1));
            ticks(int'($urandom_range(1, 30)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
